// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl
// Issue/writeback sequencer between decode and the execute unit. Accepts one
// decoded op at a time, fires a single-cycle start pulse to the EXU, waits for
// the EXU completion pulse, captures the result matching the op class and
// offers it to writeback through a valid/ready handshake. A watchdog ends the
// wait after MAX_WAIT cycles, raising a sticky timeout flag and delivering a
// non-writing, zero-data result so the pipeline never stalls forever.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   dec_*_i / dec_ready_o   decode-side offer (ready only when idle)
//   exu_start_o         one-cycle start pulse to the EXU
//   exu_aluop_o/word_o  latched op code and word flag for the EXU
//   exu_data_ok_i       EXU completion pulse
//   alu_out_i, mul_data_i, div_data_i, rem_data_i   EXU result buses
//   wb_valid_o/ready_i  writeback handshake; wb_rd_o, wb_wen_o, wb_data_o payload
//   busy_o              controller is not idle
//   timeout_err_o       sticky watchdog flag, cleared only by reset
//
// state | meaning
// IDLE  | ready for a new op from decode
// ISSUE | exu_start pulse, wait counter cleared
// WAIT  | waiting for exu_data_ok or the watchdog
// WB    | result held on wb_* until wb_ready
module exu_issue_ctrl #(
  parameter int ALUOP_WIDTH = 5,
  parameter int MAX_WAIT    = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [ALUOP_WIDTH-1:0] dec_aluop_i,
  input  logic                   dec_word_i,
  input  logic [4:0]             dec_rd_i,
  input  logic                   dec_wen_i,
  output logic                   exu_start_o,
  output logic [ALUOP_WIDTH-1:0] exu_aluop_o,
  output logic                   exu_word_o,
  input  logic                   exu_data_ok_i,
  input  logic [63:0]            alu_out_i,
  input  logic [63:0]            mul_data_i,
  input  logic [63:0]            div_data_i,
  input  logic [63:0]            rem_data_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic                   wb_wen_o,
  output logic [63:0]            wb_data_o,
  output logic                   busy_o,
  output logic                   timeout_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  localparam logic [ALUOP_WIDTH-1:0] OP_MUL  = ALUOP_WIDTH'(15);
  localparam logic [ALUOP_WIDTH-1:0] OP_DIV  = ALUOP_WIDTH'(16);
  localparam logic [ALUOP_WIDTH-1:0] OP_DIVU = ALUOP_WIDTH'(17);
  localparam logic [ALUOP_WIDTH-1:0] OP_REM  = ALUOP_WIDTH'(18);
  localparam logic [ALUOP_WIDTH-1:0] OP_REMU = ALUOP_WIDTH'(19);

  state_t state_q, state_d;

  logic [ALUOP_WIDTH-1:0] aluop_q;
  logic                   word_q;
  logic [4:0]             rd_q;
  logic                   wen_q;
  logic [7:0]             wait_cnt_q;
  logic [4:0]             wb_rd_q;
  logic                   wb_wen_q;
  logic [63:0]            wb_data_q;
  logic                   timeout_err_q;

  logic                   accept;
  logic                   exu_done;
  logic                   wait_expired;
  logic [63:0]            result_sel;

  assign accept       = (state_q == S_IDLE) && dec_valid_i;
  assign exu_done     = (state_q == S_WAIT) && exu_data_ok_i;
  // Completion takes priority over the watchdog in the same cycle.
  assign wait_expired = (state_q == S_WAIT) && !exu_data_ok_i && (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dec_valid_i) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (exu_done || wait_expired) state_d = S_WB;
      S_WB:    if (wb_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dec_ready_o = 1'b0;
    exu_start_o = 1'b0;
    wb_valid_o  = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      S_IDLE: begin
        dec_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_ISSUE: exu_start_o = 1'b1;
      S_WB:    wb_valid_o  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (aluop_q)
      OP_MUL:          result_sel = mul_data_i;
      OP_DIV, OP_DIVU: result_sel = div_data_i;
      OP_REM, OP_REMU: result_sel = rem_data_i;
      default:         result_sel = alu_out_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluop_q       <= '0;
      word_q        <= 1'b0;
      rd_q          <= '0;
      wen_q         <= 1'b0;
      wait_cnt_q    <= '0;
      wb_rd_q       <= '0;
      wb_wen_q      <= 1'b0;
      wb_data_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (accept) begin
        aluop_q <= dec_aluop_i;
        word_q  <= dec_word_i;
        rd_q    <= dec_rd_i;
        wen_q   <= dec_wen_i;
      end
      if (state_q == S_ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      if (exu_done) begin
        wb_rd_q   <= rd_q;
        wb_wen_q  <= wen_q;
        wb_data_q <= result_sel;
      end else if (wait_expired) begin
        // Deliver a harmless result so writeback drains the op normally.
        wb_rd_q       <= rd_q;
        wb_wen_q      <= 1'b0;
        wb_data_q     <= '0;
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign exu_aluop_o   = aluop_q;
  assign exu_word_o    = word_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_wen_o      = wb_wen_q;
  assign wb_data_o     = wb_data_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
module tb_exu_issue_ctrl;

  localparam int AW   = 5;
  localparam int MAXW = 70;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dec_valid = 1'b0;
  logic          dec_ready;
  logic [AW-1:0] dec_aluop = '0;
  logic          dec_word = 1'b0;
  logic [4:0]    dec_rd = '0;
  logic          dec_wen = 1'b0;
  logic          exu_start;
  logic [AW-1:0] exu_aluop;
  logic          exu_word;
  logic          exu_data_ok = 1'b0;
  logic [63:0]   alu_out = '0, mul_data = '0, div_data = '0, rem_data = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [4:0]    wb_rd;
  logic          wb_wen;
  logic [63:0]   wb_data;
  logic          busy;
  logic          timeout_err;

  exu_issue_ctrl #(.ALUOP_WIDTH(AW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_aluop_i(dec_aluop),
    .dec_word_i(dec_word), .dec_rd_i(dec_rd), .dec_wen_i(dec_wen),
    .exu_start_o(exu_start), .exu_aluop_o(exu_aluop), .exu_word_o(exu_word),
    .exu_data_ok_i(exu_data_ok),
    .alu_out_i(alu_out), .mul_data_i(mul_data), .div_data_i(div_data), .rem_data_i(rem_data),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd), .wb_wen_o(wb_wen),
    .wb_data_o(wb_data), .busy_o(busy), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (exu_start) n_start++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the age of the current op in cycles since it was
  // accepted and whether its result has been delivered, using the issue rules.
  int          m_age = 0;     // 0 = no op, 1 = start cycle, >=2 waiting
  bit          m_done = 0;
  bit          m_to = 0;
  int          m_op = 0;
  bit          m_word = 0;
  logic [4:0]  m_rd = '0;
  bit          m_wen = 0;
  logic [4:0]  m_wb_rd = '0;
  bit          m_wb_wen = 0;
  logic [63:0] m_wb_data = '0;

  function automatic logic [63:0] pick(input int op, input logic [63:0] a, m, d, r);
    if (op == 15) return m;
    if (op == 16 || op == 17) return d;
    if (op == 18 || op == 19) return r;
    return a;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_done = 0; m_to = 0;
    end else if (m_age == 0) begin
      if (dec_valid) begin
        m_age = 1; m_op = int'(dec_aluop); m_word = dec_word; m_rd = dec_rd; m_wen = dec_wen;
      end
    end else if (m_done) begin
      if (wb_ready) begin m_age = 0; m_done = 0; end
    end else begin
      if (m_age >= 2) begin
        if (exu_data_ok) begin
          m_done = 1; m_wb_rd = m_rd; m_wb_wen = m_wen;
          m_wb_data = pick(m_op, alu_out, mul_data, div_data, rem_data);
        end else if (m_age - 2 == MAXW - 1) begin
          m_done = 1; m_to = 1; m_wb_rd = m_rd; m_wb_wen = 0; m_wb_data = '0;
        end
      end
      m_age++;
    end
  end

  always @(negedge clk) begin
    chk("dec_ready", dec_ready, m_age == 0);
    chk("busy", busy, m_age != 0);
    chk("exu_start", exu_start, m_age == 1 && !m_done);
    chk("wb_valid", wb_valid, m_done);
    chk("timeout_err", timeout_err, m_to);
    if (m_done) begin
      chk("wb_rd", wb_rd, m_wb_rd);
      chk("wb_wen", wb_wen, m_wb_wen);
      chk("wb_data", wb_data, m_wb_data);
    end
    if (m_age >= 1 && !m_done) begin
      chk("exu_aluop", exu_aluop, m_op);
      chk("exu_word", exu_word, m_word);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one op. dly>0: exu_data_ok is pulsed dly cycles after exu_start;
  // dly=0: never. Cycle numbers are returned relative to the accept cycle c0.
  task automatic run_op(input int op, input bit word, input int rd, input bit wen,
                        input int dly, input int stall, input bit hold_dec,
                        output int t_start, output int t_valid, output int t_idle,
                        output logic [63:0] got_data, output int starts);
    int c0, g, s0;
    dec_valid = 1; dec_aluop = AW'(op); dec_word = word; dec_rd = 5'(rd); dec_wen = wen;
    g = 0;
    while (!dec_ready && g < 200) begin tick(); g++; end
    if (g >= 200) chk("accept_bound", 0, 1);
    s0 = n_start;
    c0 = cyc;
    tick();
    if (!hold_dec) dec_valid = 0;
    t_start = exu_start ? cyc - c0 : -1;
    if (dly > 0) begin
      repeat (dly) tick();
      exu_data_ok = 1;
      tick();
      exu_data_ok = 0;
    end
    g = 0;
    while (!wb_valid && g < 300) begin tick(); g++; end
    if (g >= 300) chk("wb_valid_bound", 0, 1);
    t_valid = cyc - c0;
    got_data = wb_data;
    for (int i = 0; i < stall; i++) begin
      exu_data_ok = (i == 4);
      if (i == 4) begin alu_out = ~alu_out; rem_data = ~rem_data; end
      tick();
    end
    exu_data_ok = 0;
    if (stall > 0) chk("wb_data_held", wb_data, got_data);
    wb_ready = 1;
    tick();
    wb_ready = 0;
    t_idle = cyc - c0;
    starts = n_start - s0;
  endtask

  int ts, tv, ti, ns;
  logic [63:0] gd;

  initial begin
    #2;
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_exu_aluop", exu_aluop, 0);
    chk("rst_exu_word", exu_word, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_wen", wb_wen, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();

    // Spurious completion pulse while idle.
    exu_data_ok = 1; alu_out = 64'hDEAD;
    tick();
    exu_data_ok = 0;
    tick();
    chk("spurious_busy", busy, 0);

    // ALU op, completion one cycle after start.
    alu_out = 64'h1234;
    run_op(0, 0, 5, 1, 1, 0, 0, ts, tv, ti, gd, ns);
    chk("alu_t_start", ts, 1);
    chk("alu_t_valid", tv, 3);
    chk("alu_data", gd, 64'h1234);
    chk("alu_t_idle", ti, 4);
    chk("alu_ready_c4", dec_ready, 1);

    // Word multiply, completion 64 cycles after start.
    mul_data = 64'hFFFF_FFFF_8000_0000; alu_out = 64'h1; div_data = 64'h2; rem_data = 64'h3;
    run_op(15, 1, 9, 1, 64, 0, 0, ts, tv, ti, gd, ns);
    chk("mul_data", gd, 64'hFFFF_FFFF_8000_0000);
    chk("mul_t_valid", tv, 66);
    chk("mul_starts", ns, 1);

    // Remainder vs divide select.
    div_data = 64'd7; rem_data = 64'd3; mul_data = 64'd11; alu_out = 64'd13;
    run_op(18, 0, 3, 1, 3, 0, 0, ts, tv, ti, gd, ns);
    chk("rem_data", gd, 64'd3);
    run_op(17, 0, 4, 1, 3, 0, 0, ts, tv, ti, gd, ns);
    chk("div_data", gd, 64'd7);

    // Backpressure with decode still offering, plus a stray completion in WB.
    alu_out = 64'hA5A5;
    run_op(2, 0, 7, 0, 2, 10, 1, ts, tv, ti, gd, ns);
    chk("bp_data", gd, 64'hA5A5);
    chk("bp_starts", ns, 1);
    chk("bp_t_idle", ti, 15);
    alu_out = 64'h77;
    run_op(1, 0, 8, 1, 1, 0, 0, ts, tv, ti, gd, ns);
    chk("after_bp_data", gd, 64'h77);

    // Completion in the very last wait cycle beats the watchdog.
    alu_out = 64'h55;
    run_op(3, 0, 6, 1, MAXW, 0, 0, ts, tv, ti, gd, ns);
    chk("edge_data", gd, 64'h55);
    chk("edge_t_valid", tv, MAXW + 2);
    chk("edge_no_timeout", timeout_err, 0);

    // Watchdog: no completion at all.
    run_op(0, 0, 10, 1, 0, 0, 0, ts, tv, ti, gd, ns);
    chk("to_t_valid", tv, MAXW + 2);
    chk("to_data", gd, 0);
    chk("to_flag", timeout_err, 1);
    alu_out = 64'h99;
    run_op(0, 0, 11, 1, 2, 0, 0, ts, tv, ti, gd, ns);
    chk("to_sticky", timeout_err, 1);
    chk("post_to_data", gd, 64'h99);

    // Reset in the middle of WAIT.
    dec_valid = 1; dec_aluop = 5'd15; dec_word = 1; dec_rd = 5'd12; dec_wen = 1;
    tick();
    dec_valid = 0;
    repeat (5) tick();
    rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_ready", dec_ready, 1);
    chk("mid_rst_aluop", exu_aluop, 0);
    chk("mid_rst_word", exu_word, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    repeat (2) tick();
    rst = 0;
    exu_data_ok = 1;
    tick();
    exu_data_ok = 0;
    repeat (4) tick();
    chk("post_rst_wb_valid", wb_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1);
  end

endmodule
